id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, with load-use hazard detection and bubble insertion built in.
- Captures decoded ID-stage control, operands and register addresses each cycle.
- Its EX-side outputs feed the ALU and the forwarding unit's EX_RSaddr1/EX_RSaddr2 inputs.
- Generates the stall request that freezes PC and IF/ID.

Parameters:
DATA_W, 32, width of register operands and immediate
ADDR_W, 5, register address width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mem_stall_i  in  1  data-memory stall; freezes this register
flush_i  in  1  taken branch/jump; squash the ID instruction
ID_valid_i  in  1  ID holds a real instruction
ID_RSaddr1_i  in  ADDR_W  rs1 address
ID_RSaddr2_i  in  ADDR_W  rs2 address
ID_RS1use_i  in  1  instruction reads rs1
ID_RS2use_i  in  1  instruction reads rs2
ID_RDaddr_i  in  ADDR_W  rd address
ID_RS1data_i  in  DATA_W  rs1 value
ID_RS2data_i  in  DATA_W  rs2 value
ID_imm_i  in  DATA_W  sign-extended immediate
ID_funct_i  in  10  {funct7,funct3}
ID_ctrl_i  in  7  {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,ALUOp[1:0]}
hazard_o  out  1  load-use stall request to PC and IF/ID (hold)
EX_valid_o  out  1  EX holds a real instruction
EX_RSaddr1_o  out  ADDR_W  to forwarding unit
EX_RSaddr2_o  out  ADDR_W  to forwarding unit
EX_RDaddr_o  out  ADDR_W  rd in EX
EX_RS1data_o  out  DATA_W  rs1 value
EX_RS2data_o  out  DATA_W  rs2 value
EX_imm_o  out  DATA_W  immediate
EX_funct_o  out  10  funct fields
EX_ctrl_o  out  7  control bundle, same layout as ID_ctrl_i

Behaviour:
- Reset: all EX_* outputs are 0 on the first edge with rst_i=1. This is a bubble.
- hazard_o is combinational and is 0 whenever EX_ctrl_o.MemRead=0.
- Load-use hazard: hazard_o = EX_valid_o & EX_ctrl_o.MemRead & ID_valid_i & (EX_RDaddr_o!=0) & ((ID_RS1use_i & EX_RDaddr_o==ID_RSaddr1_i) | (ID_RS2use_i & EX_RDaddr_o==ID_RSaddr2_i)).
- Rising-edge update priority, highest first:
  1. rst_i: clear everything.
  2. mem_stall_i: hold all EX_* unchanged. hazard_o still evaluates from current contents.
  3. flush_i: load a bubble.
  4. hazard_o: load a bubble. The ID instruction is held upstream and re-presented the next cycle.
  5. Otherwise: capture all ID_* inputs; EX_valid_o <= ID_valid_i.
- Bubble contents: EX_valid_o=0, EX_ctrl_o=0, and EX_RSaddr1/2_o=EX_RDaddr_o=0. The forwarding unit and hazard logic therefore see x0. Data, immediate and funct fields are also zeroed.
- Invalid input: if ID_valid_i=0 on a normal capture, control and address fields load as 0, identical to a bubble.
- Latency: 1 cycle ID→EX.
- Each load-use hazard inserts exactly 1 bubble. After the bubble EX no longer holds the load, so hazard_o drops.
- Simultaneous flush_i and hazard_o: a single bubble. hazard_o still asserts for that cycle; upstream flush dominates.
- Reset mid-stall: rst_i wins. hazard_o is 0 the cycle after.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- When defined:
  - Adds output ports bubble_cnt_o[31:0] and flush_cnt_o[31:0], both 0 on reset.
  - They increment on edges where a hazard bubble or a flush bubble is loaded, respectively.
  - Neither increments during mem_stall_i.
  - Both wrap 0xFFFFFFFF→0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include pipe_defs: ADDR_W, DATA_W, CTRL_W=7, and the ctrl bit indices CTRL_REGWRITE=6, CTRL_MEMTOREG=5, CTRL_MEMREAD=4, CTRL_MEMWRITE=3, CTRL_ALUSRC=2, CTRL_ALUOP=1:0.
- Forwarding and EX/MEM use the same constants.
- One natural sub-module: load_use_detect, the purely combinational hazard_o equation, reusable by the PC/IF-ID hold logic.

Test Plan:
- Reset: rst_i=1 with nonzero ID inputs → all EX_* = 0 and hazard_o=0 after the edge.
- Normal capture: ID add x3,x1,x2 (ctrl RegWrite=1) → next cycle EX_RSaddr1=1, EX_RSaddr2=2, EX_RDaddr=3, EX_ctrl=7'b1000010, EX_valid=1.
- Load-use: EX holds lw x5, ID add x6,x5,x7 → hazard_o=1; next edge EX is a bubble (ctrl=0, addrs=0); the re-presented add is captured the following edge and hazard_o=0.
- No false hazard:
  - lw x0 in EX with ID using x0 → hazard_o=0.
  - lw x5 in EX, ID instruction with RS2use=0 and rs2=5 → hazard_o=0.
- Stall hold/flush: mem_stall_i=1 for 3 cycles → EX_* constant. flush_i=1 with hazard_o=1 → exactly one bubble, and with ID_EX_STALL_CNT_EN flush_cnt_o +1 and bubble_cnt_o unchanged.

Source files
------------

// File: rtl/pipe_defs_pkg.sv
// rtl/pipe_defs_pkg.sv - shared pipeline widths and control-bundle bit indices
package pipe_defs;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int CTRL_W  = 7;
  localparam int FUNCT_W = 10;

  // {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,ALUOp[1:0]}
  localparam int CTRL_REGWRITE = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_ALUSRC   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;
endpackage

// File: rtl/id_ex_pipe_load_use_detect.sv
// rtl/id_ex_pipe_load_use_detect.sv - combinational load-use hazard detector
module load_use_detect #(
  parameter int ADDR_W = 5
) (
  input  logic              ex_valid_i,
  input  logic              ex_memread_i,
  input  logic [ADDR_W-1:0] ex_rd_i,
  input  logic              id_valid_i,
  input  logic              id_rs1use_i,
  input  logic              id_rs2use_i,
  input  logic [ADDR_W-1:0] id_rs1_i,
  input  logic [ADDR_W-1:0] id_rs2_i,
  output logic              hazard_o
);
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_rs1use_i && (ex_rd_i == id_rs1_i);
  assign rs2_hit  = id_rs2use_i && (ex_rd_i == id_rs2_i);
  // x0 is never written, so a load targeting it cannot create a dependency
  assign hazard_o = ex_valid_i && ex_memread_i && id_valid_i &&
                    (ex_rd_i != '0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with load-use bubble insertion; optional ID_EX_STALL_CNT_EN counters
module id_ex_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_stall_i,
  input  logic              flush_i,
  input  logic              ID_valid_i,
  input  logic [ADDR_W-1:0] ID_RSaddr1_i,
  input  logic [ADDR_W-1:0] ID_RSaddr2_i,
  input  logic              ID_RS1use_i,
  input  logic              ID_RS2use_i,
  input  logic [ADDR_W-1:0] ID_RDaddr_i,
  input  logic [DATA_W-1:0] ID_RS1data_i,
  input  logic [DATA_W-1:0] ID_RS2data_i,
  input  logic [DATA_W-1:0] ID_imm_i,
  input  logic [9:0]        ID_funct_i,
  input  logic [6:0]        ID_ctrl_i,
  output logic              hazard_o,
  output logic              EX_valid_o,
  output logic [ADDR_W-1:0] EX_RSaddr1_o,
  output logic [ADDR_W-1:0] EX_RSaddr2_o,
  output logic [ADDR_W-1:0] EX_RDaddr_o,
  output logic [DATA_W-1:0] EX_RS1data_o,
  output logic [DATA_W-1:0] EX_RS2data_o,
  output logic [DATA_W-1:0] EX_imm_o,
  output logic [9:0]        EX_funct_o,
  output logic [6:0]        EX_ctrl_o
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]       bubble_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);
  import pipe_defs::*;

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d, imm_q, imm_d;
  logic [9:0]        funct_q, funct_d;
  logic [6:0]        ctrl_q, ctrl_d;
  logic              hazard;

  load_use_detect #(.ADDR_W(ADDR_W)) u_load_use_detect (
    .ex_valid_i   (valid_q),
    .ex_memread_i (ctrl_q[CTRL_MEMREAD]),
    .ex_rd_i      (rd_q),
    .id_valid_i   (ID_valid_i),
    .id_rs1use_i  (ID_RS1use_i),
    .id_rs2use_i  (ID_RS2use_i),
    .id_rs1_i     (ID_RSaddr1_i),
    .id_rs2_i     (ID_RSaddr2_i),
    .hazard_o     (hazard)
  );

  always_comb begin
    valid_d = valid_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    imm_d   = imm_q;
    funct_d = funct_q;
    ctrl_d  = ctrl_q;
    if (!mem_stall_i) begin
      // flush, load-use and an empty ID slot all collapse to the same bubble
      if (flush_i || hazard || !ID_valid_i) begin
        valid_d = 1'b0;
        rs1_d   = '0;
        rs2_d   = '0;
        rd_d    = '0;
        d1_d    = '0;
        d2_d    = '0;
        imm_d   = '0;
        funct_d = '0;
        ctrl_d  = '0;
      end else begin
        valid_d = 1'b1;
        rs1_d   = ID_RSaddr1_i;
        rs2_d   = ID_RSaddr2_i;
        rd_d    = ID_RDaddr_i;
        d1_d    = ID_RS1data_i;
        d2_d    = ID_RS2data_i;
        imm_d   = ID_imm_i;
        funct_d = ID_funct_i;
        ctrl_d  = ID_ctrl_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      imm_q   <= '0;
      funct_q <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      imm_q   <= imm_d;
      funct_q <= funct_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign hazard_o     = hazard;
  assign EX_valid_o   = valid_q;
  assign EX_RSaddr1_o = rs1_q;
  assign EX_RSaddr2_o = rs2_q;
  assign EX_RDaddr_o  = rd_q;
  assign EX_RS1data_o = d1_q;
  assign EX_RS2data_o = d2_q;
  assign EX_imm_o     = imm_q;
  assign EX_funct_o   = funct_q;
  assign EX_ctrl_o    = ctrl_q;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // a flush bubble is attributed to the flush even when a hazard coincides
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (!mem_stall_i) begin
      if (flush_i)     flush_cnt_d  = flush_cnt_q + 32'd1;
      else if (hazard) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - scoreboard bench for id_ex_pipe against a behavioural pipeline model
module tb_id_ex_pipe;
  import pipe_defs::*;

  localparam logic [6:0] CTRL_R  = 7'b1000010;
  localparam logic [6:0] CTRL_LW = 7'b1110100;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid, use1, use2;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_d1, id_d2, id_imm;
  logic [9:0]  id_funct;
  logic [6:0]  id_ctrl;
  logic        hazard, ex_valid;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_d1, ex_d2, ex_imm;
  logic [9:0]  ex_funct;
  logic [6:0]  ex_ctrl;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] bubble_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_pipe #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .mem_stall_i(stall), .flush_i(flush),
    .ID_valid_i(id_valid), .ID_RSaddr1_i(id_rs1), .ID_RSaddr2_i(id_rs2),
    .ID_RS1use_i(use1), .ID_RS2use_i(use2), .ID_RDaddr_i(id_rd),
    .ID_RS1data_i(id_d1), .ID_RS2data_i(id_d2), .ID_imm_i(id_imm),
    .ID_funct_i(id_funct), .ID_ctrl_i(id_ctrl), .hazard_o(hazard),
    .EX_valid_o(ex_valid), .EX_RSaddr1_o(ex_rs1), .EX_RSaddr2_o(ex_rs2),
    .EX_RDaddr_o(ex_rd), .EX_RS1data_o(ex_d1), .EX_RS2data_o(ex_d2),
    .EX_imm_o(ex_imm), .EX_funct_o(ex_funct), .EX_ctrl_o(ex_ctrl)
`ifdef ID_EX_STALL_CNT_EN
    , .bubble_cnt_o(bubble_cnt), .flush_cnt_o(flush_cnt)
`endif
  );

  typedef struct packed {
    logic valid; logic [4:0] rs1, rs2, rd;
    logic [31:0] d1, d2, imm; logic [9:0] funct; logic [6:0] ctrl;
  } ex_t;
  typedef struct packed {
    logic rst, stall, flush, valid, use1, use2; logic [4:0] rs1, rs2, rd;
    logic [31:0] d1, d2, imm; logic [9:0] funct; logic [6:0] ctrl;
  } in_t;
  typedef struct packed {
    ex_t ex; logic hz; logic [31:0] bc, fc;
  } exp_t;

  exp_t        sb_q[$];
  ex_t         m_ex;
  logic [31:0] m_bc, m_fc;
  int          total = 0;
  int          bad = 0;

  // Spec's load-use rule, evaluated on the model's view of EX and the ID request
  function automatic logic ref_hazard(input ex_t e, input in_t i);
    logic dep;
    dep = (i.use1 && e.rd == i.rs1) || (i.use2 && e.rd == i.rs2);
    return e.valid && e.ctrl[CTRL_MEMREAD] && i.valid && (e.rd != 5'd0) && dep;
  endfunction

  function automatic in_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic u1, input logic u2,
                             input logic [6:0] ctrl);
    in_t i;
    i = '0;
    i.valid = v; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.use1 = u1; i.use2 = u2;
    i.ctrl = ctrl;
    i.d1 = $urandom; i.d2 = $urandom; i.imm = $urandom;
    i.funct = 10'($urandom);
    return i;
  endfunction

  task automatic drive(input in_t i);
    rst = i.rst; stall = i.stall; flush = i.flush; id_valid = i.valid;
    use1 = i.use1; use2 = i.use2; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
    id_d1 = i.d1; id_d2 = i.d2; id_imm = i.imm; id_funct = i.funct; id_ctrl = i.ctrl;
  endtask

  // One clock of stimulus: present inputs, predict this cycle's outputs, advance the model
  task automatic step(input in_t i);
    exp_t e;
    ex_t  nx;
    logic h;
    drive(i);
    h = ref_hazard(m_ex, i);
    e.ex = m_ex; e.hz = h; e.bc = m_bc; e.fc = m_fc;
    sb_q.push_back(e);
    nx = m_ex;
    if (i.rst) nx = '0;
    else if (i.stall) nx = m_ex;
    else if (i.flush || h || !i.valid) nx = '0;
    else begin
      nx.valid = 1'b1; nx.rs1 = i.rs1; nx.rs2 = i.rs2; nx.rd = i.rd;
      nx.d1 = i.d1; nx.d2 = i.d2; nx.imm = i.imm; nx.funct = i.funct; nx.ctrl = i.ctrl;
    end
    @(posedge clk);
    #1;
    m_ex = nx;
    if (i.rst) begin
      m_bc = 0; m_fc = 0;
    end else if (!i.stall) begin
      if (i.flush) m_fc = m_fc + 1;
      else if (h) m_bc = m_bc + 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("hazard", 32'(hazard), 32'(e.hz));
      chk("ex_valid", 32'(ex_valid), 32'(e.ex.valid));
      chk("ex_rs1", 32'(ex_rs1), 32'(e.ex.rs1));
      chk("ex_rs2", 32'(ex_rs2), 32'(e.ex.rs2));
      chk("ex_rd", 32'(ex_rd), 32'(e.ex.rd));
      chk("ex_d1", ex_d1, e.ex.d1);
      chk("ex_d2", ex_d2, e.ex.d2);
      chk("ex_imm", ex_imm, e.ex.imm);
      chk("ex_funct", 32'(ex_funct), 32'(e.ex.funct));
      chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ex.ctrl));
`ifdef ID_EX_STALL_CNT_EN
      chk("bubble_cnt", bubble_cnt, e.bc);
      chk("flush_cnt", flush_cnt, e.fc);
`endif
    end
  end

  initial begin
    in_t i;
    i = mk(1'b1, 5'd7, 5'd9, 5'd11, 1'b1, 1'b1, 7'h7f);
    i.rst = 1'b1;
    drive(i);
    @(posedge clk);
    #1;
    m_ex = '0; m_bc = 0; m_fc = 0;

    // reset with nonzero ID inputs
    step(i);
    step(i);
    // add x3,x1,x2 then observe
    step(mk(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, CTRL_R));
    step(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 7'd0));
    // lw x5 ; add x6,x5,x7 stalls one cycle then is re-presented
    step(mk(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LW));
    step(mk(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CTRL_R));
    step(mk(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CTRL_R));
    step(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 7'd0));
    // lw x0 followed by reader of x0
    step(mk(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, CTRL_LW));
    step(mk(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, CTRL_R));
    // lw x5 followed by I-type with rs2 field 5 but unused
    step(mk(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LW));
    step(mk(1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 7'b1000110));
    // three-cycle memory stall holds EX
    step(mk(1'b1, 5'd4, 5'd8, 5'd9, 1'b1, 1'b1, CTRL_R));
    for (int k = 0; k < 3; k++) begin
      i = mk(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 7'($urandom));
      i.flush = 1'($urandom);
      i.stall = 1'b1;
      step(i);
    end
    // simultaneous flush and load-use hazard
    step(mk(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LW));
    i = mk(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CTRL_R);
    i.flush = 1'b1;
    step(i);
    step(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 7'd0));
    // reset while a stall and hazard are pending
    step(mk(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LW));
    i = mk(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CTRL_R);
    i.stall = 1'b1; i.rst = 1'b1;
    step(i);
    i.rst = 1'b0; i.stall = 1'b0;
    step(i);

    // randomized traffic over a small register range so hazards are frequent
    for (int k = 0; k < 600; k++) begin
      i = mk(($urandom % 8) != 0, 5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4),
             1'($urandom), 1'($urandom), 7'($urandom));
      i.stall = ($urandom % 6) == 0;
      i.flush = ($urandom % 8) == 0;
      i.rst   = ($urandom % 60) == 0;
      step(i);
    end

    repeat (2) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
